// File: rtl/round_timer_if.sv
// Bus bundle for round_timer: control/tick inputs toward the timer, registered status back.
// master drives the controls; slave is the timer side.
interface round_timer_if;
  logic       timeout100ms;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] preset;
  logic [7:0] remaining;
  logic       busy;
  logic       expired;
  logic       done;
  logic       warn;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tenths;

  modport master (
    output timeout100ms, start, pause, abort, preset,
    input  remaining, busy, expired, done, warn, bcd_tens, bcd_ones, bcd_tenths
  );

  modport slave (
    input  timeout100ms, start, pause, abort, preset,
    output remaining, busy, expired, done, warn, bcd_tens, bcd_ones, bcd_tenths
  );
endinterface

// File: rtl/round_timer.sv
// round_timer: round countdown in 100 ms ticks; every output is registered (1 clk after inputs).
// No backpressure (inputs act on the cycle seen). ROUND_TIMER_BCD_EN adds registered BCD of remaining.
module round_timer #(
  parameter int unsigned WARN_TICKS = 30
) (
  input  logic          clk,
  input  logic          rst,
  round_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic       expired_q, expired_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       warn_q, warn_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    if (bus.abort) begin
      state_d     = IDLE;
      remaining_d = 8'd0;
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          if (bus.start && (bus.preset != 8'd0)) begin
            state_d     = RUN;
            remaining_d = bus.preset;
          end
        end
        RUN: begin
          // pause wins over a coincident tick; start is meaningless here
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (bus.timeout100ms) begin
            if (remaining_q > 8'd1) begin
              remaining_d = remaining_q - 8'd1;
            end else begin
              remaining_d = 8'd0;
              state_d     = EXPIRED;
              expired_d   = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (bus.start) begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == EXPIRED);
    warn_d = busy_d && (remaining_d != 8'd0) && (32'(remaining_d) <= WARN_TICKS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      warn_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      warn_q      <= warn_d;
    end
  end

  assign bus.remaining = remaining_q;
  assign bus.busy      = busy_q;
  assign bus.expired   = expired_q;
  assign bus.done      = done_q;
  assign bus.warn      = warn_q;

`ifdef ROUND_TIMER_BCD_EN
  logic [3:0] tens_q, ones_q, tenths_q;

  // Converted from the next value so the digits line up with remaining
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      tenths_q <= 4'd0;
    end else begin
      tens_q   <= 4'(remaining_d / 8'd100);
      ones_q   <= 4'((remaining_d / 8'd10) % 8'd10);
      tenths_q <= 4'(remaining_d % 8'd10);
    end
  end

  assign bus.bcd_tens   = tens_q;
  assign bus.bcd_ones   = ones_q;
  assign bus.bcd_tenths = tenths_q;
`else
  assign bus.bcd_tens   = 4'd0;
  assign bus.bcd_ones   = 4'd0;
  assign bus.bcd_tenths = 4'd0;
`endif

endmodule

// File: tb/tb_round_timer.sv
// Randomised + directed bench for round_timer against a rule-level reference model.
module tb_round_timer;
  localparam int WARN = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   chk_en = 1'b0;

  round_timer_if bus ();

  round_timer #(.WARN_TICKS(WARN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: round flags and a remaining-ticks counter
  bit m_running, m_paused, m_done, m_exp;
  int m_rem;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_running = 0; m_paused = 0; m_done = 0; m_exp = 0; m_rem = 0;
    end else begin
      m_exp = 0;
      if (bus.abort) begin
        m_running = 0; m_paused = 0; m_done = 0; m_rem = 0;
      end else if (!m_running && !m_paused && bus.start && bus.preset != 0) begin
        m_rem = bus.preset; m_running = 1; m_done = 0;
      end else if (m_running && bus.pause) begin
        m_running = 0; m_paused = 1;
      end else if (m_paused && bus.start) begin
        m_paused = 0; m_running = 1;
      end else if (m_running && bus.timeout100ms) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_running = 0; m_done = 1; m_exp = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit busy_e = m_running || m_paused;
      chk("m_remaining", int'(bus.remaining), m_rem);
      chk("m_busy", int'(bus.busy), int'(busy_e));
      chk("m_expired", int'(bus.expired), int'(m_exp));
      chk("m_done", int'(bus.done), int'(m_done));
      chk("m_warn", int'(bus.warn), int'(busy_e && m_rem > 0 && m_rem <= WARN));
`ifdef ROUND_TIMER_BCD_EN
      chk("m_bcd", int'({bus.bcd_tens, bus.bcd_ones, bus.bcd_tenths}),
          ((m_rem / 100) << 8) | (((m_rem / 10) % 10) << 4) | (m_rem % 10));
`else
      chk("m_bcd", int'({bus.bcd_tens, bus.bcd_ones, bus.bcd_tenths}), 0);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int p);
    bus.preset = 8'(p); bus.start = 1; cyc(1); bus.start = 0;
  endtask

  task automatic tick;
    bus.timeout100ms = 1; cyc(1); bus.timeout100ms = 0;
  endtask

  task automatic all_zero(input string name);
    chk({name, "_rem"}, int'(bus.remaining), 0);
    chk({name, "_flags"}, int'({bus.busy, bus.expired, bus.done, bus.warn}), 0);
    chk({name, "_bcd"}, int'({bus.bcd_tens, bus.bcd_ones, bus.bcd_tenths}), 0);
  endtask

  initial begin
    bus.timeout100ms = 0; bus.start = 0; bus.pause = 0; bus.abort = 0; bus.preset = 0;
    cyc(2);
    all_zero("reset");
    rst = 1;
    chk_en = 1;
    cyc(1);

    // 5-tick round, ticks 3 clk apart
    do_start(5);
    chk("r5_load", int'(bus.remaining), 5);
    chk("r5_busy", int'(bus.busy), 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("r5_rem", int'(bus.remaining), 5 - i);
      chk("r5_exp", int'(bus.expired), (i == 5) ? 1 : 0);
      cyc(2);
    end
    chk("r5_exp_single", int'(bus.expired), 0);
    chk("r5_done", int'(bus.done), 1);
    chk("r5_busy_end", int'(bus.busy), 0);

    // pause/resume with warn threshold
    do_start(40);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("p_warn_31", int'(bus.warn), 0);
      tick(); cyc(1);
    end
    chk("p_rem30", int'(bus.remaining), 30);
    chk("p_warn30", int'(bus.warn), 1);
    bus.pause = 1; cyc(1); bus.pause = 0;
    for (int i = 0; i < 7; i++) begin tick(); cyc(1); end
    chk("p_held", int'(bus.remaining), 30);
    chk("p_busy", int'(bus.busy), 1);
    bus.start = 1; bus.timeout100ms = 1; cyc(1); bus.start = 0; bus.timeout100ms = 0;
    chk("p_resume_tick_drop", int'(bus.remaining), 30);
    for (int i = 0; i < 30; i++) tick();
    chk("p_zero", int'(bus.remaining), 0);
    chk("p_done", int'(bus.done), 1);

    // abort interactions
    bus.abort = 1; cyc(1); bus.abort = 0;
    bus.preset = 20; bus.start = 1; bus.abort = 1; cyc(1); bus.start = 0; bus.abort = 0;
    chk("ab_idle_rem", int'(bus.remaining), 0);
    chk("ab_idle_busy", int'(bus.busy), 0);
    do_start(20);
    for (int i = 0; i < 8; i++) tick();
    chk("ab_rem12", int'(bus.remaining), 12);
    bus.abort = 1; cyc(1); bus.abort = 0;
    chk("ab_run_rem", int'(bus.remaining), 0);
    chk("ab_run_exp", int'(bus.expired), 0);
    chk("ab_run_done", int'(bus.done), 0);

    // async reset mid-round
    do_start(10);
    for (int i = 0; i < 3; i++) tick();
    chk("rs_rem7", int'(bus.remaining), 7);
    #2 rst = 0;
    #1 all_zero("rs_async");
    @(negedge clk) rst = 1;
    for (int i = 0; i < 5; i++) tick();
    all_zero("rs_after");

    // preset 0, preset 255, coincident tick
    do_start(0);
    chk("z_rem", int'(bus.remaining), 0);
    chk("z_busy", int'(bus.busy), 0);
    bus.preset = 8'd255; bus.start = 1; bus.timeout100ms = 1; cyc(1);
    bus.start = 0; bus.timeout100ms = 0;
    chk("f_rem255", int'(bus.remaining), 255);
`ifdef ROUND_TIMER_BCD_EN
    chk("f_bcd255", int'({bus.bcd_tens, bus.bcd_ones, bus.bcd_tenths}), 'h255);
`endif
    bus.preset = 8'd3; tick();
    chk("f_preset_change", int'(bus.remaining), 254);
    bus.abort = 1; cyc(1); bus.abort = 0;

    // randomised traffic checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      bus.abort        = ($urandom_range(0, 63) == 0);
      bus.start        = ($urandom_range(0, 7) == 0);
      bus.pause        = ($urandom_range(0, 15) == 0);
      bus.timeout100ms = ($urandom_range(0, 2) == 0);
      bus.preset       = ($urandom_range(0, 15) == 0) ? 8'd0 :
                         ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) :
                                                       8'($urandom_range(1, 40));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 0;
        @(negedge clk) rst = 1;
      end else begin
        cyc(1);
      end
    end
    bus.abort = 0; bus.start = 0; bus.pause = 0; bus.timeout100ms = 0;
    cyc(2);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
